rpn_stack_core: RTL

Stack-based reverse-Polish arithmetic core for the calculator board. It takes single-cycle command pulses (push/add/mul/pop/clear) and the 8-bit DIP operand, already debounced and edge-detected upstream. It keeps the operand stack and presents the current top-of-stack plus status flags. The 16-bit `top` output feeds the BCD/seven-segment display driver directly downstream.

---
 rtl/rpn_stack_core_if.sv | 40 ++++
 rtl/rpn_stack_core.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rpn_stack_core_if.sv
// Command/status bundle between the calculator front end and the RPN core.
//   master: drives data_in and the one-cycle command pulses, observes status.
//   slave : the core; samples commands, drives top/count/flags.
//   data_in            8-bit DIP operand
//   push/add/mul/pop/clear  one-cycle command pulses
//   top, count         top-of-stack value and entry count
//   empty/single/full  decoded from count
//   busy               arithmetic in flight
//   ovf/unf            sticky overflow / underflow
interface rpn_stack_core_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]       data_in;
    logic             push;
    logic             add;
    logic             mul;
    logic             pop;
    logic             clear;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             single;
    logic             full;
    logic             busy;
    logic             ovf;
    logic             unf;

    modport master (
        output data_in, push, add, mul, pop, clear,
        input  top, count, empty, single, full, busy, ovf, unf
    );

    modport slave (
        input  data_in, push, add, mul, pop, clear,
        output top, count, empty, single, full, busy, ovf, unf
    );
endinterface

// File: rtl/rpn_stack_core.sv
// Reverse-Polish stack core. The top entry lives in its own register so the
// display sees it directly; the entries below it sit in mem[0..DEPTH-2], with
// mem[count-2] being next-on-stack. add/mul take two cycles: the first latches
// NOS and the opcode, the second (EXEC) writes the result.
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    rpn_stack_core_if slave: commands in, top/count/status out
module rpn_stack_core #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    rpn_stack_core_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] top_q;
    logic [WIDTH-1:0] nos_q;
    logic [CW-1:0]    cnt_q;
    logic             op_mul_q;
    logic             ovf_q;
    logic             unf_q;
    logic             busy;
    logic [WIDTH-1:0] mem [DEPTH-1];

    // One-hot priority decode: clear > push > add > mul > pop.
    logic do_push, do_add, do_mul, do_pop;
    assign do_push = bus.push & ~bus.clear;
    assign do_add  = bus.add  & ~bus.clear & ~bus.push;
    assign do_mul  = bus.mul  & ~bus.clear & ~bus.push & ~bus.add;
    assign do_pop  = bus.pop  & ~bus.clear & ~bus.push & ~bus.add & ~bus.mul;

    logic can_push, has_two, has_one, accept_arith, mem_we;
    assign can_push = (cnt_q < CW'(DEPTH));
    assign has_two  = (cnt_q >= CW'(2));
    assign has_one  = (cnt_q != '0);
    assign accept_arith = (state == IDLE) && (do_add || do_mul) && has_two;
    // Push with a non-empty stack spills the old top into the array.
    assign mem_we = (state == IDLE) && do_push && can_push && has_one;

    logic [IW-1:0] wr_idx, rd_idx;
    assign wr_idx = IW'(cnt_q - CW'(1));
    assign rd_idx = IW'(cnt_q - CW'(2));

    // Both ops are taken modulo 2^WIDTH: the WIDTH-bit context drops the
    // carry and the upper half of the product.
    logic [WIDTH-1:0] alu;
    assign alu = op_mul_q ? nos_q * top_q : nos_q + top_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_arith) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.clear) state_nxt = IDLE;
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        if (state == EXEC) busy = 1'b1;
    end

    // Datapath and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q    <= '0;
            nos_q    <= '0;
            cnt_q    <= '0;
            op_mul_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (bus.clear) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (state == EXEC) begin
            // Anything other than clear is dropped while executing.
            top_q <= alu;
            cnt_q <= cnt_q - CW'(1);
        end else if (do_push) begin
            if (can_push) begin
                top_q <= WIDTH'(bus.data_in);
                cnt_q <= cnt_q + CW'(1);
            end else begin
                ovf_q <= 1'b1;
            end
        end else if (do_add || do_mul) begin
            if (has_two) begin
                nos_q    <= mem[rd_idx];
                op_mul_q <= do_mul;
            end else begin
                unf_q <= 1'b1;
            end
        end else if (do_pop) begin
            if (has_one) begin
                top_q <= has_two ? mem[rd_idx] : '0;
                cnt_q <= cnt_q - CW'(1);
            end else begin
                unf_q <= 1'b1;
            end
        end
    end

    // Stack body is never reset: reads are always qualified by count.
    always_ff @(posedge clk) begin
        if (reset && !bus.clear && mem_we) mem[wr_idx] <= top_q;
    end

    assign bus.top    = top_q;
    assign bus.count  = cnt_q;
    assign bus.empty  = (cnt_q == '0);
    assign bus.single = (cnt_q == CW'(1));
    assign bus.full   = (cnt_q == CW'(DEPTH));
    assign bus.busy   = busy;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
endmodule
